rvvi_frame_arbiter: RTL and testbench
=====================================

# rvvi_frame_arbiter

- Frame-atomic, round-robin arbiter that shares one 32-bit AXI4 write-data channel (Ethernet MAC TX side) between two frame sources.
  - Port 0: the RVVI packetizer.
  - Port 1: the host control/ack frame generator.
- Enforces a programmable inter-frame gap.
- Sits between the frame sources and the MAC, so the trace stream and control traffic never interleave within a frame.

## Interface
Parameters:
- MAX_GAP_BITS, 32: width of the gap counter and of the GapCycles input.
- STAT_BITS, 32: width of the per-port frame counters.

Ports:
- m_axi_aclk  in  1  clock; one clock domain, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- S0Wdata / S1Wdata  in  32  source word.
- S0Wvalid / S1Wvalid  in  1  source word valid; also serves as the request.
- S0Wlast / S1Wlast  in  1  last word of the source frame.
- S0Wready / S1Wready  out  1  source word accepted.
- MWdata  out  32  granted source data.
- MWstrb  out  4  constant 4'hF.
- MWlast  out  1  granted source last.
- MWvalid  out  1  granted source valid.
- MWready  in  1  MAC ready.
- GapCycles  in  MAX_GAP_BITS  idle cycles inserted after each frame; sampled every cycle while in GAP.
- Busy  out  1  state != IDLE.
- GrantId  out  1  port currently or last granted.
- FrameCount0 / FrameCount1  out  STAT_BITS  completed frames per port.

## Operation
- States: IDLE, GRANT0, GRANT1, GAP.
- IDLE:
  - Only S0Wvalid -> GRANT0. Only S1Wvalid -> GRANT1. Neither -> IDLE.
  - Both valid -> grant the port not equal to LastGrant, then LastGrant updates to the granted port.
- GRANTx:
  - MWdata/MWlast/MWvalid = SxW*.
  - SxWready = MWready. The other port's ready = 0.
  - A beat transfers when MWvalid & MWready.
  - The grant holds until a beat with SxWlast transfers. The source dropping valid mid-frame does not release the grant.
- End of frame (last beat transfers):
  - GapCycles == 0 -> IDLE.
  - Otherwise -> GAP, with GapCnt cleared to 0.
- GAP:
  - GapCnt increments each cycle.
  - Exit to IDLE when GapCnt+1 >= GapCycles, compared unsigned at full width.
  - A GapCycles change during GAP takes effect immediately.
- Outside GRANTx: MWvalid = 0, both ready = 0, MWdata/MWlast = 0.
- GrantId = LastGrant.
- Busy = state != IDLE.
- No combinational path from any Wvalid to any Wready. Ready depends only on state and MWready.

## Timing
- Reset values:
  - State IDLE, LastGrant = 1 (port 0 wins the first tie), GapCnt 0, FrameCount0/1 = 0.
  - All ready/valid/last outputs 0, MWdata 0, Busy 0, GrantId 1.
- Arbitration latency:
  - SxWvalid rises in cycle N while IDLE -> GRANTx in N+1.
  - The first beat can transfer in N+1.
- Gap: last beat in cycle N, GapCycles = G > 0 -> GAP for cycles N+1..N+G, IDLE at N+G+1, next grant at N+G+2.
- G = 0: IDLE at N+1, next grant at N+2. One dead cycle minimum between frames.
- Backpressure: while MWready = 0, the granted source sees ready 0 and must hold its data stable. The arbiter adds no buffering.
- Reset mid-frame: next edge forces IDLE. The partially sent frame is abandoned; the MAC must tolerate the truncated frame.
- Counters wrap modulo 2^STAT_BITS.

## Configuration
- RVVI_ARB_STATS_EN defined:
  - FrameCount0/1 increment by 1 on each transferred last beat of the respective port.
- Not defined:
  - Counter registers are not instantiated. FrameCount0/1 are tied to 0.
  - All other behaviour is identical.

## Test plan
- Single source: S0 sends a 4-word frame A0..A3, GapCycles = 0, MWready = 1.
  - MWdata A0..A3 on 4 consecutive cycles; MWlast only on A3; Busy drops 1 cycle after A3.
  - FrameCount0 = 1 (stats on).
- Tie: S0 and S1 both raise valid in the same IDLE cycle after reset.
  - S0 frame is fully sent first, then S1's.
  - The next tie grants S0 again, since LastGrant = 1.
  - No interleaved words at MW.
- Gap: GapCycles = 3, S1 sends a 2-word frame, then S0 valid is held.
  - Exactly 3 GAP cycles plus 1 IDLE cycle elapse between S1's last beat and S0's first beat.
- Backpressure: MWready low for 5 cycles mid-frame.
  - Granted ready low for the same 5 cycles; other port ready stays 0.
  - Data resumes without loss or duplication.
- Reset at word 2 of 6: next cycle IDLE, MWvalid 0, counters 0, GrantId 1.
  - A new S0 frame afterwards is granted normally.
- Stats wrap with STAT_BITS = 4: after 17 S0 frames, FrameCount0 = 1.
  - With the macro off, both counters read 0 throughout.

Source files
------------

// File: rtl/rvvi_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one 32-bit AXI4 write-data channel between two frame sources.
// Define RVVI_ARB_STATS_EN to instantiate the per-port completed-frame counters.
module rvvi_frame_arbiter #(
  parameter int MAX_GAP_BITS = 32,
  parameter int STAT_BITS    = 32
) (
  input  logic                    m_axi_aclk,
  input  logic                    reset,
  input  logic [31:0]             S0Wdata,
  input  logic                    S0Wvalid,
  input  logic                    S0Wlast,
  output logic                    S0Wready,
  input  logic [31:0]             S1Wdata,
  input  logic                    S1Wvalid,
  input  logic                    S1Wlast,
  output logic                    S1Wready,
  output logic [31:0]             MWdata,
  output logic [3:0]              MWstrb,
  output logic                    MWlast,
  output logic                    MWvalid,
  input  logic                    MWready,
  input  logic [MAX_GAP_BITS-1:0] GapCycles,
  output logic                    Busy,
  output logic                    GrantId,
  output logic [STAT_BITS-1:0]    FrameCount0,
  output logic [STAT_BITS-1:0]    FrameCount1
);

  // state  | meaning
  // IDLE   | no frame in flight; arbitrate between requesting sources
  // GRANT0 | port 0 owns the MAC channel until its last beat transfers
  // GRANT1 | port 1 owns the MAC channel until its last beat transfers
  // GAP    | inter-frame gap; leaves once GapCnt+1 >= GapCycles
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t                  r_state, w_next_state;
  logic                    r_last_grant, w_next_last_grant;
  logic [MAX_GAP_BITS-1:0] r_gap_cnt, w_next_gap_cnt;
  logic [MAX_GAP_BITS:0]   w_gap_inc;
  logic                    w_end0, w_end1;

  assign w_end0    = (r_state == S_GRANT0) && S0Wvalid && MWready && S0Wlast;
  assign w_end1    = (r_state == S_GRANT1) && S1Wvalid && MWready && S1Wlast;
  // One extra bit so the gap compare cannot wrap at full counter width.
  assign w_gap_inc = {1'b0, r_gap_cnt} + (MAX_GAP_BITS + 1)'(1);

  always_ff @(posedge m_axi_aclk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gap_cnt    <= '0;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_last_grant;
      r_gap_cnt    <= w_next_gap_cnt;
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_next_last_grant = r_last_grant;
    w_next_gap_cnt    = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (S0Wvalid && (!S1Wvalid || r_last_grant)) begin
          w_next_state      = S_GRANT0;
          w_next_last_grant = 1'b0;
        end else if (S1Wvalid) begin
          w_next_state      = S_GRANT1;
          w_next_last_grant = 1'b1;
        end
      end
      S_GRANT0, S_GRANT1: begin
        if (w_end0 || w_end1) begin
          w_next_gap_cnt = '0;
          w_next_state   = (GapCycles == '0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        w_next_gap_cnt = w_gap_inc[MAX_GAP_BITS-1:0];
        if (w_gap_inc >= {1'b0, GapCycles}) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    MWdata   = '0;
    MWlast   = 1'b0;
    MWvalid  = 1'b0;
    S0Wready = 1'b0;
    S1Wready = 1'b0;
    case (r_state)
      S_GRANT0: begin
        MWdata   = S0Wdata;
        MWlast   = S0Wlast;
        MWvalid  = S0Wvalid;
        S0Wready = MWready;
      end
      S_GRANT1: begin
        MWdata   = S1Wdata;
        MWlast   = S1Wlast;
        MWvalid  = S1Wvalid;
        S1Wready = MWready;
      end
      default: ;
    endcase
  end

  assign MWstrb  = 4'hF;
  assign Busy    = (r_state != S_IDLE);
  assign GrantId = r_last_grant;

`ifdef RVVI_ARB_STATS_EN
  logic [STAT_BITS-1:0] r_frame_cnt0, r_frame_cnt1;

  always_ff @(posedge m_axi_aclk) begin
    if (reset) begin
      r_frame_cnt0 <= '0;
      r_frame_cnt1 <= '0;
    end else begin
      if (w_end0) r_frame_cnt0 <= r_frame_cnt0 + STAT_BITS'(1);
      if (w_end1) r_frame_cnt1 <= r_frame_cnt1 + STAT_BITS'(1);
    end
  end

  assign FrameCount0 = r_frame_cnt0;
  assign FrameCount1 = r_frame_cnt1;
`else
  assign FrameCount0 = '0;
  assign FrameCount1 = '0;
`endif

endmodule

// File: tb/tb_rvvi_frame_arbiter.sv
// Randomized bench for rvvi_frame_arbiter against a frame-level ownership model.
module tb_rvvi_frame_arbiter;
  localparam int GB    = 32;
  localparam int SB    = 4;
  localparam int NCYC  = 4000;

  logic          m_axi_aclk = 1'b0;
  logic          reset;
  logic [31:0]   S0Wdata, S1Wdata, MWdata;
  logic          S0Wvalid, S1Wvalid, S0Wlast, S1Wlast, S0Wready, S1Wready;
  logic [3:0]    MWstrb;
  logic          MWlast, MWvalid, MWready;
  logic [GB-1:0] GapCycles;
  logic          Busy, GrantId;
  logic [SB-1:0] FrameCount0, FrameCount1;

  logic [31:0] src_data  [2];
  logic        src_valid [2];
  logic        src_last  [2];
  bit          src_in_frame [2];
  bit          src_hold  [2];
  int          src_len   [2];
  int          src_idx   [2];
  int          src_frame [2];

  assign S0Wdata  = src_data[0];
  assign S0Wvalid = src_valid[0];
  assign S0Wlast  = src_last[0];
  assign S1Wdata  = src_data[1];
  assign S1Wvalid = src_valid[1];
  assign S1Wlast  = src_last[1];

  rvvi_frame_arbiter #(.MAX_GAP_BITS(GB), .STAT_BITS(SB)) dut (
    .m_axi_aclk (m_axi_aclk),
    .reset      (reset),
    .S0Wdata    (S0Wdata),
    .S0Wvalid   (S0Wvalid),
    .S0Wlast    (S0Wlast),
    .S0Wready   (S0Wready),
    .S1Wdata    (S1Wdata),
    .S1Wvalid   (S1Wvalid),
    .S1Wlast    (S1Wlast),
    .S1Wready   (S1Wready),
    .MWdata     (MWdata),
    .MWstrb     (MWstrb),
    .MWlast     (MWlast),
    .MWvalid    (MWvalid),
    .MWready    (MWready),
    .GapCycles  (GapCycles),
    .Busy       (Busy),
    .GrantId    (GrantId),
    .FrameCount0(FrameCount0),
    .FrameCount1(FrameCount1)
  );

  always #5 m_axi_aclk = ~m_axi_aclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: who owns the channel, whether a gap is running, and completed frames.
  int          owner;
  bit          in_gap;
  int          last_end;
  logic        m_last_grant;
  int          m_cnt [2];
  int          low_run;

  task automatic drive_source(input int p);
    if (!src_in_frame[p] && $urandom_range(0, 3) == 0) begin
      src_in_frame[p] = 1'b1;
      src_len[p]      = $urandom_range(1, 6);
      src_idx[p]      = 0;
      src_frame[p]    = src_frame[p] + 1;
    end
    if (src_hold[p]) begin
      // unaccepted word stays on the bus unchanged
    end else if (src_in_frame[p] && $urandom_range(0, 3) != 0) begin
      src_valid[p] = 1'b1;
      src_data[p]  = {p[0], src_frame[p][14:0], src_idx[p][15:0]};
      src_last[p]  = (src_idx[p] == src_len[p] - 1);
    end else begin
      src_valid[p] = 1'b0;
      src_data[p]  = $urandom;
      src_last[p]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic source_handshake(input int p, input logic rdy);
    if (src_valid[p] && rdy) begin
      src_hold[p] = 1'b0;
      if (src_last[p]) src_in_frame[p] = 1'b0;
      else             src_idx[p]      = src_idx[p] + 1;
    end else begin
      src_hold[p] = src_valid[p];
    end
  endtask

  function automatic logic [31:0] exp_count(input int n);
`ifdef RVVI_ARB_STATS_EN
    return 32'(n % (1 << SB));
`else
    return 32'(n - n);
`endif
  endfunction

  initial begin
    logic [31:0] exp_data;
    logic        exp_valid, exp_last, exp_rdy0, exp_rdy1, exp_busy;
    logic [31:0] k;

    reset     = 1'b1;
    MWready   = 1'b0;
    GapCycles = '0;
    for (int p = 0; p < 2; p++) begin
      src_data[p] = '0; src_valid[p] = 1'b0; src_last[p] = 1'b0;
      src_in_frame[p] = 1'b0; src_hold[p] = 1'b0;
      src_len[p] = 0; src_idx[p] = 0; src_frame[p] = p * 1000;
      m_cnt[p] = 0;
    end
    repeat (3) @(posedge m_axi_aclk);
    @(negedge m_axi_aclk);
    #1;
    check("rst_busy",    32'(Busy),        32'd0);
    check("rst_grantid", 32'(GrantId),     32'd1);
    check("rst_mwvalid", 32'(MWvalid),     32'd0);
    check("rst_mwlast",  32'(MWlast),      32'd0);
    check("rst_mwdata",  MWdata,           32'd0);
    check("rst_rdy0",    32'(S0Wready),    32'd0);
    check("rst_rdy1",    32'(S1Wready),    32'd0);
    check("rst_cnt0",    32'(FrameCount0), 32'd0);
    check("rst_cnt1",    32'(FrameCount1), 32'd0);
    check("rst_strb",    32'(MWstrb),      32'hF);

    owner = -1; in_gap = 1'b0; last_end = 0; m_last_grant = 1'b1; low_run = 0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge m_axi_aclk);
      drive_source(0);
      drive_source(1);
      reset = ($urandom_range(0, 249) == 0);
      if (low_run > 0) begin
        low_run = low_run - 1;
        MWready = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        low_run = 4;
        MWready = 1'b0;
      end else begin
        MWready = ($urandom_range(0, 4) != 0);
      end
      if ($urandom_range(0, 5) == 0)
        GapCycles = ($urandom_range(0, 9) < 9) ? GB'($urandom_range(0, 4)) : '1;
      #1;

      exp_data = '0; exp_valid = 1'b0; exp_last = 1'b0; exp_rdy0 = 1'b0; exp_rdy1 = 1'b0;
      if (owner >= 0) begin
        exp_data  = src_data[owner];
        exp_valid = src_valid[owner];
        exp_last  = src_last[owner];
        if (owner == 0) exp_rdy0 = MWready;
        else            exp_rdy1 = MWready;
      end
      exp_busy = (owner >= 0) || in_gap;
      check("mwdata",  MWdata,            exp_data);
      check("mwvalid", 32'(MWvalid),      32'(exp_valid));
      check("mwlast",  32'(MWlast),       32'(exp_last));
      check("rdy0",    32'(S0Wready),     32'(exp_rdy0));
      check("rdy1",    32'(S1Wready),     32'(exp_rdy1));
      check("busy",    32'(Busy),         32'(exp_busy));
      check("grantid", 32'(GrantId),      32'(m_last_grant));
      check("cnt0",    32'(FrameCount0),  exp_count(m_cnt[0]));
      check("cnt1",    32'(FrameCount1),  exp_count(m_cnt[1]));

      source_handshake(0, S0Wready);
      source_handshake(1, S1Wready);

      if (reset) begin
        owner = -1; in_gap = 1'b0; m_last_grant = 1'b1;
        m_cnt[0] = 0; m_cnt[1] = 0;
        for (int p = 0; p < 2; p++) begin
          src_in_frame[p] = 1'b0;
          src_hold[p]     = 1'b0;
        end
      end else if (owner >= 0) begin
        if (src_valid[owner] && MWready && src_last[owner]) begin
          m_cnt[owner] = m_cnt[owner] + 1;
          owner = -1;
          if (GapCycles != '0) begin
            in_gap   = 1'b1;
            last_end = c;
          end
        end
      end else if (in_gap) begin
        k = 32'(c - last_end);
        if (k >= GapCycles) in_gap = 1'b0;
      end else if (src_valid[0] || src_valid[1]) begin
        if (src_valid[0] && src_valid[1]) owner = m_last_grant ? 0 : 1;
        else                              owner = src_valid[0] ? 0 : 1;
        m_last_grant = owner[0];
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
